// File: rtl/spi_sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_arb_pkg
// Description : Shared definitions for the spi_sram round-robin arbiter.
//               Holds the sequencer state encoding, the default address width
//               and the fixed read length used for every read command.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_sram_arb_pkg;

  localparam int ADDR_W = 24;

  // Every requester transaction is a single byte.
  localparam logic [5:0] CMD_READ_SIZE = 6'd1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    ISSUE = 3'd2,
    GUARD = 3'd3,
    WAIT  = 3'd4,
    POP   = 3'd5,
    ACK   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority picker. Selects the first
//               set request bit at or after rr_ptr, wrapping at N_REQ.
// Ports       : req         - request vector
//               rr_ptr      - index holding highest priority
//               grant_valid - at least one request is set
//               grant_idx   - index of the selected requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  int w_pos;

  // Walk offsets from farthest to nearest so the nearest set bit is the
  // last assignment and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_pos       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = (int'(rr_ptr) + k) % N_REQ;
      if (req[w_pos]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_arbiter
// Description : Round-robin arbiter sharing one spi_sram controller among
//               N_REQ byte-wide requesters. Sequences data push, command
//               pulse, done wait and data pop on the winner's behalf.
// Ports       : pll_clk/rst_n      - clock, synchronous active-low reset
//               req/we/addr/wdata  - per-requester request, flat vectors
//               ack/rdata/err/busy - completion pulse, read byte, abort, busy
//               sram_*             - spi_sram FIFO and command handshake
// Options     : SRAM_ARB_TIMEOUT_EN - enables the TIMEOUT_CYCLES watchdog;
//               when undefined err is tied low and waits are unbounded.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sram_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = spi_sram_arb_pkg::ADDR_W,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    pll_clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*8-1:0]      wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [7:0]              rdata,
  output logic                    err,
  output logic                    busy,
  input  logic                    sram_done,
  output logic [7:0]              sram_data_in,
  output logic                    sram_data_in_valid,
  input  logic [7:0]              sram_data_out,
  output logic                    sram_data_out_read,
  input  logic                    sram_data_out_empty,
  output logic                    sram_write_cmd,
  output logic                    sram_read_cmd,
  output logic [5:0]              sram_read_cmd_size,
  output logic [ADDR_W-1:0]       sram_address
);

  import spi_sram_arb_pkg::*;

  localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_idx_w-1:0]   r_rr_ptr;
  logic [c_idx_w-1:0]   r_gnt;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [7:0]           r_wdata;
  logic [7:0]           r_rdata;
  logic                 r_busy;
  logic                 w_pick_valid;
  logic [c_idx_w-1:0]   w_pick_idx;
  logic                 w_grant;
  logic                 w_timeout;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (c_idx_w)
  ) u_rr_pick (
    .req         (req),
    .rr_ptr      (r_rr_ptr),
    .grant_valid (w_pick_valid),
    .grant_idx   (w_pick_idx)
  );

  assign rdata              = r_rdata;
  assign busy               = r_busy;
  assign sram_data_in       = r_wdata;
  assign sram_address       = r_addr;
  assign sram_read_cmd_size = CMD_READ_SIZE;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int c_cnt_w = ($clog2(TIMEOUT_CYCLES + 1) > 16) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 16;

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_err;
  logic               w_active;

  assign w_active  = (r_state == PUSH) || (r_state == ISSUE) || (r_state == GUARD) ||
                     (r_state == WAIT) || (r_state == POP);
  assign w_timeout = w_active && (r_cnt == c_cnt_w'(TIMEOUT_CYCLES));
  assign err       = (r_state == ACK) && r_err;

  always_ff @(posedge pll_clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_grant) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (w_active) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_next_state       = r_state;
    w_grant            = 1'b0;
    ack                = '0;
    sram_data_in_valid = 1'b0;
    sram_write_cmd     = 1'b0;
    sram_read_cmd      = 1'b0;
    sram_data_out_read = 1'b0;
    case (r_state)
      IDLE: begin
        if (sram_done && w_pick_valid) begin
          w_grant      = 1'b1;
          w_next_state = we[w_pick_idx] ? PUSH : ISSUE;
        end
      end
      PUSH: begin
        sram_data_in_valid = 1'b1;
        w_next_state       = ISSUE;
      end
      ISSUE: begin
        sram_write_cmd = r_we;
        sram_read_cmd  = ~r_we;
        w_next_state   = GUARD;
      end
      // done may still read high for a cycle after the command; skip it.
      GUARD: w_next_state = WAIT;
      WAIT: begin
        if (sram_done) w_next_state = r_we ? ACK : POP;
      end
      POP: begin
        if (!sram_data_out_empty) begin
          sram_data_out_read = 1'b1;
          w_next_state       = ACK;
        end
      end
      ACK: begin
        ack[r_gnt]   = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    // An abort suppresses any handshake strobe so the controller is not
    // left with a half-issued operation and rdata stays untouched.
    if (w_timeout) begin
      w_next_state       = ACK;
      sram_data_in_valid = 1'b0;
      sram_write_cmd     = 1'b0;
      sram_read_cmd      = 1'b0;
      sram_data_out_read = 1'b0;
    end
  end

  always_ff @(posedge pll_clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_gnt   <= w_pick_idx;
        r_we    <= we[w_pick_idx];
        r_addr  <= addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
        r_wdata <= wdata[int'(w_pick_idx)*8 +: 8];
        r_busy  <= 1'b1;
        if (int'(w_pick_idx) == N_REQ - 1) r_rr_ptr <= '0;
        else                               r_rr_ptr <= w_pick_idx + 1'b1;
      end
      if (sram_data_out_read) r_rdata <= sram_data_out;
      if (r_state == ACK)     r_busy  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_sram_arbiter
// Description : Self-checking bench for spi_sram_arbiter (N_REQ=2,
//               TIMEOUT_CYCLES=100) with a behavioural spi_sram model and a
//               round-robin / memory reference kept in plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sram_arbiter;

  localparam int N = 2;

  logic          pll_clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  we;
  logic [N*24-1:0] addr;
  logic [N*8-1:0]  wdata;
  logic [N-1:0]  ack;
  logic [7:0]    rdata;
  logic          err;
  logic          busy;
  logic          sram_done;
  logic [7:0]    sram_data_in;
  logic          sram_data_in_valid;
  logic [7:0]    sram_data_out;
  logic          sram_data_out_read;
  logic          sram_data_out_empty;
  logic          sram_write_cmd;
  logic          sram_read_cmd;
  logic [5:0]    sram_read_cmd_size;
  logic [23:0]   sram_address;

  always #5 pll_clk = ~pll_clk;

  spi_sram_arbiter #(.N_REQ(N), .ADDR_W(24), .TIMEOUT_CYCLES(100)) dut (
    .pll_clk             (pll_clk),
    .rst_n               (rst_n),
    .req                 (req),
    .we                  (we),
    .addr                (addr),
    .wdata               (wdata),
    .ack                 (ack),
    .rdata               (rdata),
    .err                 (err),
    .busy                (busy),
    .sram_done           (sram_done),
    .sram_data_in        (sram_data_in),
    .sram_data_in_valid  (sram_data_in_valid),
    .sram_data_out       (sram_data_out),
    .sram_data_out_read  (sram_data_out_read),
    .sram_data_out_empty (sram_data_out_empty),
    .sram_write_cmd      (sram_write_cmd),
    .sram_read_cmd       (sram_read_cmd),
    .sram_read_cmd_size  (sram_read_cmd_size),
    .sram_address        (sram_address)
  );

  // Per-requester transaction currently presented.
  logic        t_we    [N];
  logic [23:0] t_addr  [N];
  logic [7:0]  t_wdata [N];

  always_comb begin
    we    = '0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      we[i]           = t_we[i];
      addr[i*24 +: 24] = t_addr[i];
      wdata[i*8 +: 8]  = t_wdata[i];
    end
  end

  // ---------------- spi_sram behavioural model ----------------
  int          spi_delay  = 0;
  bit          stuck_done = 1'b0;
  int          empty_hold = 0;
  logic [7:0]  smem [256];
  logic        m_busy, m_rd, in_valid, out_valid, m_hold_act;
  logic [7:0]  m_addr8, in_byte, out_byte;
  int          m_cnt, m_hold;

  assign sram_data_out       = out_byte;
  assign sram_data_out_empty = ~out_valid;

  always @(posedge pll_clk) begin
    if (!rst_n) begin
      sram_done  <= 1'b1;
      m_busy     <= 1'b0;
      m_rd       <= 1'b0;
      in_valid   <= 1'b0;
      out_valid  <= 1'b0;
      m_hold_act <= 1'b0;
      m_hold     <= 0;
      m_cnt      <= 0;
      m_addr8    <= 8'h00;
      in_byte    <= 8'h00;
      out_byte   <= 8'h00;
    end else begin
      if (sram_data_in_valid) begin
        in_byte  <= sram_data_in;
        in_valid <= 1'b1;
      end
      if (sram_data_out_read) out_valid <= 1'b0;
      if (sram_write_cmd || sram_read_cmd) begin
        sram_done <= 1'b0;
        m_busy    <= 1'b1;
        m_rd      <= sram_read_cmd;
        m_addr8   <= sram_address[7:0];
        m_cnt     <= spi_delay;
      end else if (m_busy) begin
        if (m_cnt > 0) m_cnt <= m_cnt - 1;
        else if (!stuck_done) begin
          m_busy    <= 1'b0;
          sram_done <= 1'b1;
          if (m_rd) begin
            m_hold_act <= 1'b1;
            m_hold     <= empty_hold;
          end else begin
            smem[m_addr8] <= in_byte;
            in_valid      <= 1'b0;
          end
        end
      end
      if (m_hold_act) begin
        if (m_hold == 0) begin
          out_byte   <= smem[m_addr8];
          out_valid  <= 1'b1;
          m_hold_act <= 1'b0;
        end else m_hold <= m_hold - 1;
      end
    end
  end

  // ---------------- reference state and checking ----------------
  int         checks = 0;
  int         errors = 0;
  int         exp_ptr = 0;
  logic [7:0] exp_mem [256];
  logic [7:0] exp_rdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_txn(input int i);
    t_we[i]    = 1'($urandom);
    t_addr[i]  = {16'h0011, 6'b001000, 2'($urandom)};
    t_wdata[i] = 8'($urandom);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   32'(ack), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_addr"},  32'(sram_address), 0);
    chk({tag, "_size"},  32'(sram_read_cmd_size), 1);
    chk({tag, "_strobes"},
        32'({sram_data_in_valid, sram_write_cmd, sram_read_cmd, sram_data_out_read}), 0);
  endtask

  // Presents n0/n1 transactions on requesters 0/1 and checks every ack
  // against the round-robin rule and the reference memory.
  task automatic serve(input int n0, input int n1, input int budget);
    int rem [N];
    int cyc, pushes, wcmds, rcmds, pops, g;
    logic [7:0]  push_byte;
    logic [23:0] cmd_addr;
    bit prev_ack;
    rem[0] = n0; rem[1] = n1;
    req = {rem[1] > 0, rem[0] > 0};
    cyc = 0; pushes = 0; wcmds = 0; rcmds = 0; pops = 0; prev_ack = 1'b0;
    push_byte = 8'h00; cmd_addr = 24'h0;
    while ((rem[0] + rem[1]) > 0 && cyc < budget) begin
      @(negedge pll_clk);
      cyc++;
      if (prev_ack) chk("busy_low_after_ack", 32'(busy), 0);
      prev_ack = 1'b0;
      if (sram_data_in_valid) begin pushes++; push_byte = sram_data_in; end
      if (sram_write_cmd) begin wcmds++; cmd_addr = sram_address; end
      if (sram_read_cmd) begin
        rcmds++; cmd_addr = sram_address;
        chk("read_cmd_size", 32'(sram_read_cmd_size), 1);
      end
      if (sram_data_out_read) begin
        pops++;
        chk("pop_only_when_nonempty", 32'(sram_data_out_empty), 0);
      end
      if (ack != '0) begin
        g = (rem[exp_ptr] > 0) ? exp_ptr : (exp_ptr + 1) % N;
        chk("ack_index", 32'(ack), 32'(1) << g);
        chk("err_on_ack", 32'(err), 0);
        chk("busy_at_ack", 32'(busy), 1);
        chk("push_count", 32'(pushes), 32'(t_we[g]));
        chk("write_cmd_count", 32'(wcmds), 32'(t_we[g]));
        chk("read_cmd_count", 32'(rcmds), 32'(!t_we[g]));
        chk("pop_count", 32'(pops), 32'(!t_we[g]));
        chk("cmd_address", 32'(cmd_addr), 32'(t_addr[g]));
        if (t_we[g]) begin
          chk("push_byte", 32'(push_byte), 32'(t_wdata[g]));
          exp_mem[t_addr[g][7:0]] = t_wdata[g];
        end else begin
          exp_rdata = exp_mem[t_addr[g][7:0]];
          chk("rdata", 32'(rdata), 32'(exp_rdata));
        end
        exp_ptr = (g + 1) % N;
        rem[g]--;
        if (rem[g] > 0) rand_txn(g);
        req[g] = rem[g] > 0;
        spi_delay = $urandom_range(0, 5);
        pushes = 0; wcmds = 0; rcmds = 0; pops = 0;
        prev_ack = 1'b1;
      end
    end
    chk("serve_completed_in_budget", 32'(rem[0] + rem[1]), 0);
    req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

  initial begin
    int n0, n1, busy_c, ack_c, acks;
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) begin
      t_we[i] = 1'b0; t_addr[i] = 24'h0; t_wdata[i] = 8'h00;
    end
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    repeat (3) @(negedge pll_clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge pll_clk);

    // Single write then read-back through the other requester.
    t_we[0] = 1'b1; t_addr[0] = 24'h001122; t_wdata[0] = 8'hAA;
    spi_delay = 3;
    serve(1, 0, 100);
    t_we[1] = 1'b0; t_addr[1] = 24'h001122;
    serve(0, 1, 100);
    chk("readback_AA", 32'(rdata), 32'h0000_00AA);

    // Fill the remaining addresses used by the random phase.
    t_we[0] = 1'b1; t_addr[0] = 24'h001120; t_wdata[0] = 8'h5C;
    t_we[1] = 1'b1; t_addr[1] = 24'h001121; t_wdata[1] = 8'h3E;
    serve(1, 1, 100);
    t_we[0] = 1'b1; t_addr[0] = 24'h001123; t_wdata[0] = 8'hC7;
    serve(1, 0, 100);

    // Contention: both requesters held for two transactions each.
    rand_txn(0); rand_txn(1);
    serve(2, 2, 300);

    // Random mixes of simultaneous requests.
    for (int r = 0; r < 8; r++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      rand_txn(0); rand_txn(1);
      serve(n0, n1, 60 * (n0 + n1) + 20);
    end

    // Output FIFO stays empty for five cycles at POP.
    empty_hold = 5;
    t_we[0] = 1'b0; t_addr[0] = 24'h001121;
    serve(1, 0, 100);
    chk("rdata_after_empty_hold", 32'(rdata), 32'(exp_mem[8'h21]));
    empty_hold = 0;

    // done never returns high.
    stuck_done = 1'b1;
    t_we[0] = 1'b0; t_addr[0] = 24'h001120;
    req = 2'b01;
    busy_c = -1; ack_c = -1; acks = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge pll_clk);
      if (busy && busy_c < 0) busy_c = c;
      if (ack != '0) begin
        acks++;
        if (ack_c < 0) begin
          ack_c = c;
          chk("timeout_ack_index", 32'(ack), 1);
          chk("timeout_err", 32'(err), 1);
          chk("timeout_rdata_kept", 32'(rdata), 32'(exp_rdata));
          req = '0;
        end
      end
    end
`ifdef SRAM_ARB_TIMEOUT_EN
    chk("timeout_single_ack", 32'(acks), 1);
    chk("timeout_window", 32'((ack_c - busy_c + 1) >= 100 && (ack_c - busy_c + 1) <= 104), 1);
`else
    chk("no_ack_without_timeout", 32'(acks), 0);
    chk("busy_held_while_stuck", 32'(busy), 1);
    chk("err_tied_low", 32'(err), 0);
`endif
    req = '0;
    rst_n = 1'b0;
    stuck_done = 1'b0;
    @(negedge pll_clk);
    rst_n = 1'b1;
    exp_ptr = 0; exp_rdata = 8'h00;
    @(negedge pll_clk);

    // Reset while waiting for done on a write; the write is abandoned.
    spi_delay = 30;
    t_we[0] = 1'b1; t_addr[0] = 24'h001123; t_wdata[0] = 8'h99;
    req = 2'b01;
    busy_c = 0;
    for (int c = 0; c < 20 && !busy; c++) @(negedge pll_clk);
    chk("busy_before_wait_reset", 32'(busy), 1);
    repeat (6) @(negedge pll_clk);
    req = '0;
    rst_n = 1'b0;
    @(negedge pll_clk);
    chk_reset_vals("reset_in_wait");
    rst_n = 1'b1;
    exp_ptr = 0; exp_rdata = 8'h00;
    spi_delay = 2;
    t_we[1] = 1'b0; t_addr[1] = 24'h001123;
    serve(0, 1, 100);
    chk("abandoned_write_not_stored", 32'(rdata), 32'(exp_mem[8'h23]));
    t_we[0] = 1'b1; t_addr[0] = 24'h001123; t_wdata[0] = 8'h99;
    serve(1, 0, 100);
    t_we[1] = 1'b0;
    serve(0, 1, 100);
    chk("post_reset_readback", 32'(rdata), 32'h0000_0099);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
